// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, frame constants and a
// small helper used when sizing counters.
package uart_pkg;

  localparam int UART_FRAME_TICKS_8N1 = 10;
  localparam int UART_DATA_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_FRAME = 2'd2,
    ST_GAP   = 2'd3
  } uart_sched_state_e;

  function automatic int uart_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Request arbiter for the UART transmit scheduler. Returns a one-hot grant and
// its encoded index. The search normally starts at the round-robin pointer.
// Build option UART_TX_SCHED_FIXED_PRIO_EN: the search always starts at index
// 0 (lowest index wins) and the pointer input is ignored.
module uart_rr_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               fixed_prio_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [IDX_W-1:0] start_idx;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^{ptr_i, fixed_prio_i};
  assign start_idx = '0;
`else
  assign start_idx = fixed_prio_i ? '0 : ptr_i;
`endif

  // Walk the requesters once starting at start_idx; the first asserted one wins.
  always_comb begin
    int cand;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(start_idx) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between several byte sources. Grants one
// requester at a time, holds tx_start_send until the transmitter consumes a
// baud tick, then times the frame and the inter-frame gap by counting baud
// ticks because the transmitter has no busy output.
// Build option UART_TX_SCHED_FIXED_PRIO_EN (inside uart_rr_arbiter) switches
// from round-robin to fixed lowest-index priority.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame owned; arbitrate and latch the winner's byte
// ST_START | tx_start_send high, waiting for the tick that starts the frame
// ST_FRAME | counting FRAME_TICKS baud ticks while the frame shifts out
// ST_GAP   | counting GAP_TICKS idle baud ticks before the next grant
module uart_tx_scheduler import uart_pkg::*; #(
  parameter int NUM_REQ     = 3,
  parameter int FRAME_TICKS = UART_FRAME_TICKS_8N1,
  parameter int GAP_TICKS   = 1
) (
  input  logic                         clk_50mhz,
  input  logic                         rst_n,
  input  logic                         baud_clk_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [UART_DATA_W-1:0]       tx_data,
  output logic                         tx_start_send,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(uart_max(FRAME_TICKS, GAP_TICKS) + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  uart_sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]     win_onehot;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_valid;
  logic [UART_DATA_W-1:0] win_data;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i        (req_valid),
    .ptr_i        (rr_ptr_q),
    .fixed_prio_i (1'b0),
    .gnt_o        (win_onehot),
    .gnt_idx_o    (win_idx),
    .gnt_valid_o  (win_valid)
  );

  // Select the winning requester's byte from the one-hot grant.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) win_data = req_data[UART_DATA_W*i +: UART_DATA_W];
    end
  end

  // Next-state and register updates; the counter restarts on every state entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    req_ready_d = '0;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d     = ST_START;
          cnt_d       = '0;
          tx_data_d   = win_data;
          req_ready_d = win_onehot;
          grant_id_d  = win_idx;
          rr_ptr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      ST_START: begin
        if (baud_clk_en) begin
          state_d = ST_FRAME;
          cnt_d   = '0;
        end
      end
      ST_FRAME: begin
        if (baud_clk_en) begin
          if (cnt_q == FRAME_LAST) begin
            state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (baud_clk_en) begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      req_ready_q <= req_ready_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign tx_data       = tx_data_q;
  assign grant_id      = grant_id_q;
  assign tx_start_send = (state_q == ST_START);
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with default parameters
// (NUM_REQ=3, FRAME_TICKS=10, GAP_TICKS=1).
module tb_uart_tx_scheduler;

  logic        clk_50mhz;
  logic        rst_n;
  logic        baud_clk_en;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start_send;
  logic        busy;
  logic [1:0]  grant_id;

  int n_cmp;
  int n_err;

  uart_tx_scheduler dut (
    .clk_50mhz     (clk_50mhz),
    .rst_n         (rst_n),
    .baud_clk_en   (baud_clk_en),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_start_send (tx_start_send),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given baud enable, then settle 1 time unit.
  task automatic cyc(input logic b);
    baud_clk_en = b;
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic tick();
    cyc(1'b0);
    cyc(1'b1);
  endtask

  // After the start tick: 10 frame ticks keep busy, the 11th (gap) releases it.
  task automatic frame_ticks(input string tag);
    for (int t = 0; t < 10; t++) tick();
    chk({tag, "_busy_after10"}, 32'(busy), 32'h1);
    chk({tag, "_start_low_in_frame"}, 32'(tx_start_send), 32'h0);
    tick();
    chk({tag, "_idle_after11"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int exp_order [4];
    n_cmp = 0;
    n_err = 0;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0};
`endif
    rst_n       = 1'b0;
    baud_clk_en = 1'b0;
    req_valid   = 3'b000;
    req_data    = 24'h000000;
    cyc(1'b0);
    cyc(1'b0);

    // reset values
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_start", 32'(tx_start_send), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    rst_n = 1'b1;
    cyc(1'b0);

    // single request from requester 1
    req_data  = 24'h004100;
    req_valid = 3'b010;
    cyc(1'b0);
    chk("single_ready", 32'(req_ready), 32'h2);
    chk("single_start", 32'(tx_start_send), 32'h1);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_tx_data", 32'(tx_data), 32'h41);
    chk("single_grant_id", 32'(grant_id), 32'h1);
    cyc(1'b0);
    req_valid = 3'b000;
    chk("single_ready_pulse", 32'(req_ready), 32'h0);
    chk("single_start_held", 32'(tx_start_send), 32'h1);
    cyc(1'b1);
    chk("single_start_fall", 32'(tx_start_send), 32'h0);
    chk("single_busy_frame", 32'(busy), 32'h1);
    frame_ticks("single");
    chk("single_tx_data_hold", 32'(tx_data), 32'h41);

    // baud tick coinciding with the grant edge is not the start tick
    req_data  = 24'h000055;
    req_valid = 3'b001;
    cyc(1'b1);
    chk("coin_ready", 32'(req_ready), 32'h1);
    chk("coin_start", 32'(tx_start_send), 32'h1);
    cyc(1'b0);
    req_valid = 3'b000;
    chk("coin_not_start", 32'(tx_start_send), 32'h1);
    cyc(1'b1);
    chk("coin_start_fall", 32'(tx_start_send), 32'h0);
    frame_ticks("coin");

    // requester 2 withdraws while requester 0 owns the scheduler
    req_data  = 24'h770066;
    req_valid = 3'b001;
    cyc(1'b0);
    chk("wd_ready0", 32'(req_ready), 32'h1);
    chk("wd_tx_data", 32'(tx_data), 32'h66);
    cyc(1'b0);
    req_valid = 3'b100;
    cyc(1'b0);
    cyc(1'b0);
    chk("wd_no_ready", 32'(req_ready), 32'h0);
    req_valid = 3'b000;
    cyc(1'b1);
    frame_ticks("wd");
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    chk("wd_still_idle", 32'(busy), 32'h0);
    chk("wd_ready_idle", 32'(req_ready), 32'h0);
    chk("wd_tx_data_kept", 32'(tx_data), 32'h66);

    // reset during FRAME; a held request is re-granted after release
    req_data  = 24'h998800;
    req_valid = 3'b010;
    cyc(1'b0);
    chk("rstm_ready1", 32'(req_ready), 32'h2);
    chk("rstm_tx_data", 32'(tx_data), 32'h88);
    req_valid = 3'b110;
    cyc(1'b0);
    req_valid = 3'b100;
    cyc(1'b1);
    for (int t = 0; t < 5; t++) tick();
    chk("rstm_busy_frame", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstm_ready", 32'(req_ready), 32'h0);
    chk("rstm_tx_data_rst", 32'(tx_data), 32'h0);
    chk("rstm_start", 32'(tx_start_send), 32'h0);
    chk("rstm_busy", 32'(busy), 32'h0);
    chk("rstm_grant_id", 32'(grant_id), 32'h0);
    cyc(1'b0);
    rst_n = 1'b1;
    cyc(1'b0);
    chk("rstm_regrant_ready", 32'(req_ready), 32'h4);
    chk("rstm_regrant_id", 32'(grant_id), 32'h2);
    chk("rstm_regrant_data", 32'(tx_data), 32'h99);
    chk("rstm_regrant_start", 32'(tx_start_send), 32'h1);

    // three simultaneous requests held valid
    rst_n     = 1'b0;
    req_valid = 3'b000;
    cyc(1'b0);
    req_data  = 24'h302010;
    req_valid = 3'b111;
    rst_n     = 1'b1;
    for (int g = 0; g < 4; g++) begin
      cyc(1'b0);
      chk("rr_grant_id", 32'(grant_id), 32'(exp_order[g]));
      chk("rr_ready", 32'(req_ready), 32'(1) << exp_order[g]);
      chk("rr_tx_data", 32'(tx_data), 32'(8'h10 * (exp_order[g] + 1)));
      chk("rr_start", 32'(tx_start_send), 32'h1);
      cyc(1'b0);
      chk("rr_ready_pulse", 32'(req_ready), 32'h0);
      cyc(1'b1);
      chk("rr_start_fall", 32'(tx_start_send), 32'h0);
      frame_ticks("rr");
    end
    req_valid = 3'b000;
    cyc(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
